// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BEQ    = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_BNE    = 4'd12,
        ST_IDLE   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Shared with the datapath ALU control.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW)   ||
               (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mips_ctrl_outdec
// Purpose  : Combinational decode of the control state into datapath strobes.
// Revision : 1.0 - initial release
// ============================================================================
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic        mem_ready,
    input  logic [5:0]  opcode,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        branch_ne,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        retire,
    output logic        illegal
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        retire        = 1'b0;
        illegal       = 1'b0;

        case (state)
            ST_FETCH: begin
                // PC+4 is computed every cycle but only committed with the IR load.
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                illegal   = !opcode_legal(opcode);
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            ST_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            ST_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_BEQ, ST_BNE: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                branch_ne     = (state == ST_BNE);
                retire        = 1'b1;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mips_mc_ctrl
// Purpose  : Multi-cycle MIPS control FSM: state register and next-state logic.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        branch_ne,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t r_state;
    state_t w_next;

    // Asynchronous entry to IDLE makes every decoded output drop at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = ST_EXEC;
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_BEQ:       w_next = ST_BEQ;
                    OP_BNE:       w_next = ST_BNE;
                    OP_ADDI:      w_next = ST_ADDIEX;
                    OP_J:         w_next = ST_JUMP;
                    default:      w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                if (opcode == OP_LW) begin
                    w_next = ST_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next = ST_MEMWR;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_MEMRD:  w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  w_next = ST_FETCH;
            ST_MEMWR:  w_next = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_next = ST_ALUWB;
            ST_ALUWB:  w_next = ST_FETCH;
            ST_ADDIEX: w_next = ST_ADDIWB;
            ST_ADDIWB: w_next = ST_FETCH;
            ST_BEQ:    w_next = ST_FETCH;
            ST_BNE:    w_next = ST_FETCH;
            ST_JUMP:   w_next = ST_FETCH;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign state = r_state;

    mips_ctrl_outdec u_outdec (
        .state         (r_state),
        .mem_ready     (mem_ready),
        .opcode        (opcode),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .retire        (retire),
        .illegal       (illegal)
    );

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mips_mc_ctrl
// Purpose  : Directed self-checking bench for the multi-cycle control unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        retire, illegal;
    logic [3:0]  state;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .retire        (retire),
        .illegal       (illegal),
        .state         (state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
    } exp_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] act;
        logic [63:0] exp;
    } lit_t;

    exp_t        exp_q[$];
    lit_t        lit_q[$];
    int          compared    = 0;
    int          mismatched  = 0;
    int          retire_seen = 0;
    int          illegal_seen = 0;
    logic [63:0] obs = '0;

    // Output-centric view: each strobe is described by the states that raise it.
    function automatic logic [18:0] model_ctrl(input logic [3:0] st, input logic rdy,
                                               input logic [5:0] op);
        logic legal, pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ret, ill;
        logic [1:0] srcb, aop, psrc;
        legal = op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
        pcw   = (st == 4'd0 && rdy) || st == 4'd9;
        pcwc  = st inside {4'd8, 4'd12};
        bne   = (st == 4'd12);
        iord  = st inside {4'd3, 4'd5};
        mrd   = st inside {4'd0, 4'd3};
        mwr   = (st == 4'd5);
        irw   = (st == 4'd0 && rdy);
        m2r   = (st == 4'd4);
        rdst  = (st == 4'd7);
        rw    = st inside {4'd4, 4'd7, 4'd11};
        srca  = st inside {4'd2, 4'd6, 4'd8, 4'd10, 4'd12};
        srcb  = (st == 4'd0) ? 2'b01 : (st == 4'd1) ? 2'b11 :
                (st == 4'd2 || st == 4'd10) ? 2'b10 : 2'b00;
        aop   = (st == 4'd6) ? 2'b10 : (st == 4'd8 || st == 4'd12) ? 2'b01 : 2'b00;
        psrc  = (st == 4'd8 || st == 4'd12) ? 2'b01 : (st == 4'd9) ? 2'b10 : 2'b00;
        ret   = (st inside {4'd4, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12}) || (st == 4'd5 && rdy);
        ill   = (st == 4'd1) && !legal;
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
                srcb, aop, psrc, ret, ill};
    endfunction

    function automatic string lit_name(input logic [7:0] id);
        case (id)
            8'd0:    return "seq_boot_add";
            8'd1:    return "seq_lw_stall";
            8'd2:    return "seq_sw_stall";
            8'd3:    return "seq_beq";
            8'd4:    return "seq_bne";
            8'd5:    return "seq_addi";
            8'd6:    return "seq_j";
            8'd7:    return "seq_illegal";
            8'd8:    return "retire_count";
            8'd9:    return "illegal_count";
            8'd10:   return "reg_write_before_reset";
            8'd11:   return "reg_write_after_reset";
            8'd12:   return "state_after_reset";
            8'd13:   return "seq_reset_recover";
            8'd14:   return "seq_after_illegal";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [63:0] nib_mask(input int n);
        return (n >= 16) ? '1 : ((64'd1 << (4 * n)) - 64'd1);
    endfunction

    // Single compare process: per-cycle model check, then any queued literal checks.
    logic [22:0] act_v, exp_v;
    exp_t        cur;
    lit_t        lc;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur   = exp_q.pop_front();
            exp_v = {cur.st, model_ctrl(cur.st, cur.rdy, cur.op)};
            act_v = {state, pc_write, pc_write_cond, branch_ne, i_or_d, mem_read,
                     mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source, retire, illegal};
            compared++;
            if (act_v !== exp_v) begin
                mismatched++;
                $display("FAIL cycle @%0t: {state,ctrl} actual %h required %h",
                         $time, act_v, exp_v);
            end
            obs = {obs[59:0], state};
            if (retire)  retire_seen++;
            if (illegal) illegal_seen++;
        end
        while (lit_q.size() > 0) begin
            lc = lit_q.pop_front();
            compared++;
            if (lc.act !== lc.exp) begin
                mismatched++;
                $display("FAIL %s: actual %h required %h", lit_name(lc.id), lc.act, lc.exp);
            end
        end
    end

    task automatic post(input logic [7:0] id, input logic [63:0] act, input logic [63:0] exp);
        lit_q.push_back({id, act, exp});
    endtask

    task automatic step(input logic [3:0] st, input logic rdy);
        mem_ready = rdy;
        exp_q.push_back({st, rdy, opcode});
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge with the DUT in FETCH; returns just after the
    // edge that starts the next instruction.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                             input logic [7:0] seq_id, input int n, input logic [63:0] seq,
                             input int exp_ret, input int exp_ill);
        int r0, i0;
        r0 = retire_seen;
        i0 = illegal_seen;
        opcode = op;
        for (int k = 0; k < fst; k++) step(4'd0, 1'b0);
        step(4'd0, 1'b1);
        step(4'd1, 1'($urandom_range(0, 1)));
        case (op)
            6'h00: begin
                step(4'd6, 1'($urandom_range(0, 1)));
                step(4'd7, 1'($urandom_range(0, 1)));
            end
            6'h23: begin
                step(4'd2, 1'($urandom_range(0, 1)));
                for (int k = 0; k < mst; k++) step(4'd3, 1'b0);
                step(4'd3, 1'b1);
                step(4'd4, 1'($urandom_range(0, 1)));
            end
            6'h2b: begin
                step(4'd2, 1'($urandom_range(0, 1)));
                for (int k = 0; k < mst; k++) step(4'd5, 1'b0);
                step(4'd5, 1'b1);
            end
            6'h04: step(4'd8, 1'($urandom_range(0, 1)));
            6'h05: step(4'd12, 1'($urandom_range(0, 1)));
            6'h08: begin
                step(4'd10, 1'($urandom_range(0, 1)));
                step(4'd11, 1'($urandom_range(0, 1)));
            end
            6'h02: step(4'd9, 1'($urandom_range(0, 1)));
            default: ;
        endcase
        post(seq_id, obs & nib_mask(n), seq);
        post(8'd8, 64'(retire_seen - r0), 64'(exp_ret));
        post(8'd9, 64'(illegal_seen - i0), 64'(exp_ill));
    endtask

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        @(posedge clk);
        #1;
        repeat (10) step(4'hF, 1'b1);
        reset = 1'b1;
        step(4'hF, 1'b1);

        run_instr(6'h00, 0, 0, 8'd0, 5, 64'hF0167,   1, 0);
        run_instr(6'h23, 0, 2, 8'd1, 7, 64'h0123334, 1, 0);
        run_instr(6'h2b, 1, 1, 8'd2, 6, 64'h001255,  1, 0);
        run_instr(6'h04, 0, 0, 8'd3, 3, 64'h018,     1, 0);
        run_instr(6'h05, 0, 0, 8'd4, 3, 64'h01C,     1, 0);
        run_instr(6'h08, 2, 0, 8'd5, 6, 64'h0001AB,  1, 0);
        run_instr(6'h02, 0, 0, 8'd6, 3, 64'h019,     1, 0);
        run_instr(6'h3f, 0, 0, 8'd7, 2, 64'h01,      0, 1);
        run_instr(6'h00, 0, 0, 8'd14, 6, 64'h010167, 1, 0);

        // Abort an R-type in its write-back cycle with an asynchronous reset.
        opcode = 6'h00;
        step(4'd0, 1'b1);
        step(4'd1, 1'b1);
        step(4'd6, 1'b1);
        post(8'd10, 64'(reg_write), 64'd1);
        reset = 1'b0;
        #1;
        post(8'd11, 64'(reg_write), 64'd0);
        post(8'd12, 64'(state), 64'hF);
        mem_ready = 1'b1;
        exp_q.push_back({4'hF, 1'b1, opcode});
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(4'hF, 1'b1);
        run_instr(6'h00, 0, 0, 8'd13, 9, 64'h016FF0167, 1, 0);

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
